// File: rtl/if_id_queue_pkg.sv
// Shared defines for the IF/ID instruction queue: reset level, zero word,
// stall encodings and default bus widths.
package if_id_queue_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;

endpackage

// File: rtl/if_id_queue_inst_fifo.sv
// inst_fifo: DEPTH-entry circular buffer of {pc, inst} with registered occupancy.
// clear has priority over push/pop; storage itself is never reset.
module inst_fifo
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID stage with an instruction queue so fetch keeps running while decode stalls.
// Optional IF_ID_QUEUE_BYPASS_EN: an empty, unstalled queue forwards a push straight into decode.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W   = InstAddrBus,
  parameter int INST_W   = InstBus,
  parameter int DEPTH    = 4,
  parameter int STALL_W  = 6,
  parameter int ID_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [ADDR_W-1:0]      if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic                   if_ready,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int W = ADDR_W + INST_W;

  logic         id_stall;
  logic         push;
  logic         bypass;
  logic         fifo_push;
  logic         fifo_pop;
  logic         full;
  logic         empty;
  logic [W-1:0] head;
  logic         unused_stall;

  // Only the decode bit of the stall vector matters here.
  assign unused_stall = ^stall;
  assign id_stall     = (stall[ID_STAGE] == Stop);

  assign if_ready = (rst != RstEnable) && !full && !flush;
  assign push     = if_valid && if_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = push && empty && !id_stall;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push && !bypass;
  assign fifo_pop  = !id_stall && !flush;

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata ({if_pc, if_inst}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Decode register: flush and empty-queue loads both produce a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      id_valid <= 1'b0;
      id_pc    <= ADDR_W'(ZeroWord);
      id_inst  <= INST_W'(ZeroWord);
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= ADDR_W'(ZeroWord);
      id_inst  <= INST_W'(ZeroWord);
    end else if (!id_stall) begin
      if (bypass) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end else if (!empty) begin
        id_valid <= 1'b1;
        {id_pc, id_inst} <= head;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= ADDR_W'(ZeroWord);
        id_inst  <= INST_W'(ZeroWord);
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 4, STALL_W = 6, ID_STAGE = 2, CW = 3;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [STALL_W-1:0] stall = '0;
  logic               flush = 1'b0;
  logic               if_valid = 1'b0;
  logic [31:0]        if_pc = '0;
  logic [31:0]        if_inst = '0;
  logic               if_ready;
  logic               id_valid;
  logic [31:0]        id_pc;
  logic [31:0]        id_inst;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  logic        m_v = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .STALL_W(STALL_W), .ID_STAGE(ID_STAGE)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return rst && !flush && (q.size() < DEPTH);
  endfunction

  task automatic model_clear();
    q.delete();
    m_v = 1'b0; m_pc = '0; m_inst = '0;
  endtask

  // Reference behaviour of one rising edge, using inputs as held at that edge.
  task automatic model_step();
    bit p, done;
    ent_t e;
    p = if_valid && m_ready();
    done = 0;
    if (!rst) begin
      model_clear();
      p = 0;
    end else if (flush) begin
      model_clear();
      p = 0;
    end else if (!stall[ID_STAGE]) begin
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (p && q.size() == 0) begin
        m_v = 1'b1; m_pc = if_pc; m_inst = if_inst;
        p = 0; done = 1;
      end
`endif
      if (!done) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_v = 1'b1; m_pc = e.pc; m_inst = e.inst;
        end else begin
          m_v = 1'b0; m_pc = '0; m_inst = '0;
        end
      end
    end
    if (p) q.push_back({if_pc, if_inst});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({if_ready, id_valid, id_pc, id_inst, count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b pc=%h inst=%h cnt=%0d want all 0",
               if_ready, id_valid, id_pc, id_inst, count);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if ({if_ready, id_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_release got rdy=%b v=%b cnt=%0d want rdy=1 v=0 cnt=0", if_ready, id_valid, count);
    end
    tick();
  endtask

  task automatic test_single();
    int n;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h2401_0001;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", if_ready);
    end
    tick();
    if_valid = 1'b0;
    n = 1;
    while (!id_valid && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT || id_pc !== 32'h100 || id_inst !== 32'h2401_0001) begin
      errors++;
      $display("FAIL single_latency got lat=%0d pc=%h inst=%h want lat=%0d pc=100 inst=24010001",
               n, id_pc, id_inst, LAT);
    end
    tick();
    checks++;
    if (count !== 3'd0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got cnt=%0d v=%b want cnt=0 v=0", count, id_valid);
    end
  endtask

  task automatic test_full_stall();
    int idx, cyc;
    logic r;
    logic [31:0] got[$];
    int at[$];
    idx = 0;
    stall = 6'b000100;
    for (int c = 0; c < 6; c++) begin
      if_valid = 1'b1; if_pc = 32'h100 + 32'(4 * idx); if_inst = 32'hA000_0000 | 32'(idx);
      #1 r = if_ready;
      tick();
      if (r) idx++;
    end
    checks++;
    if (count !== 3'd4 || if_ready !== 1'b0 || idx !== 4) begin
      errors++;
      $display("FAIL full_stall got cnt=%0d rdy=%b pushed=%0d want cnt=4 rdy=0 pushed=4", count, if_ready, idx);
    end
    stall = '0;
    cyc = 0;
    while (got.size() < 5 && cyc < 20) begin
      if_valid = (idx < 5); if_pc = 32'h100 + 32'(4 * idx); if_inst = 32'hA000_0000 | 32'(idx);
      #1 r = if_ready && if_valid;
      tick();
      if (r) idx++;
      cyc++;
      checks++;
      if ({id_valid, id_pc, id_inst, count} !== {m_v, m_pc, m_inst, CW'(q.size())}) begin
        errors++;
        $display("FAIL full_drain_model got v=%b pc=%h cnt=%0d want v=%b pc=%h cnt=%0d",
                 id_valid, id_pc, count, m_v, m_pc, q.size());
      end
      if (id_valid) begin
        got.push_back(id_pc);
        at.push_back(cyc);
      end
    end
    if_valid = 1'b0;
    checks++;
    if (got.size() !== 5) begin
      errors++;
      $display("FAIL full_drain_count got %0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 32'h100 + 32'(4 * i)) begin
          errors++;
          $display("FAIL full_order[%0d] got %h want %h", i, got[i], 32'h100 + 32'(4 * i));
        end
      end
      checks++;
      if (at[3] - at[0] !== 3) begin
        errors++;
        $display("FAIL full_consecutive got span=%0d want 3", at[3] - at[0]);
      end
    end
  endtask

  task automatic test_bubble();
    if_valid = 1'b0; stall = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({id_valid, id_pc, id_inst} !== '0) begin
        errors++;
        $display("FAIL bubble got v=%b pc=%h inst=%h want 0", id_valid, id_pc, id_inst);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    stall = 6'b000100;
    for (int c = 0; c < 3; c++) begin
      if_valid = 1'b1; if_pc = 32'h300 + 32'(4 * c); if_inst = $urandom;
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_fill got cnt=%0d want 3", count);
    end
    flush = 1'b1; if_pc = 32'hDEAD; if_inst = 32'hBEEF;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b want 0", if_ready);
    end
    tick();
    flush = 1'b0; if_valid = 1'b0;
    checks++;
    if ({count, id_valid, id_pc, id_inst} !== '0) begin
      errors++;
      $display("FAIL flush_clear got cnt=%0d v=%b pc=%h want all 0", count, id_valid, id_pc);
    end
    stall = '0; if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h1234_5678;
    tick();
    if_valid = 1'b0;
    n = 1;
    while (!id_valid && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT || id_pc !== 32'h200 || id_inst !== 32'h1234_5678) begin
      errors++;
      $display("FAIL flush_next got lat=%0d pc=%h inst=%h want lat=%0d pc=200", n, id_pc, id_inst, LAT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int N = 2 * DEPTH + 3;
    ent_t sent[N];
    ent_t got[$];
    int idx, stalls;
    logic r;
    for (int i = 0; i < N; i++) sent[i] = {32'h1000 + 32'(4 * i), 32'($urandom)};
    idx = 0; stalls = 0; stall = '0;
    for (int c = 0; c < N + 6; c++) begin
      if_valid = (idx < N);
      if (idx < N) {if_pc, if_inst} = sent[idx];
      #1 r = if_ready;
      if (if_valid && !r) stalls++;
      tick();
      if (if_valid && r) idx++;
      checks++;
      if ({id_valid, id_pc, id_inst, count} !== {m_v, m_pc, m_inst, CW'(q.size())}) begin
        errors++;
        $display("FAIL b2b_model got v=%b pc=%h cnt=%0d want v=%b pc=%h cnt=%0d",
                 id_valid, id_pc, count, m_v, m_pc, q.size());
      end
      if (id_valid) got.push_back({id_pc, id_inst});
    end
    if_valid = 1'b0;
    checks++;
    if (got.size() !== N || stalls !== 0) begin
      errors++;
      $display("FAIL b2b_count got n=%0d backpressure=%0d want n=%0d backpressure=0", got.size(), stalls, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (got[i] !== sent[i]) begin
          errors++;
          $display("FAIL b2b_order[%0d] got %h want %h", i, got[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      stall    = STALL_W'($urandom);
      stall[ID_STAGE] = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 19) == 0);
      if_valid = ($urandom_range(0, 9) < 6);
      if_pc    = $urandom;
      if_inst  = $urandom;
      #1;
      checks++;
      if (if_ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready got %b want %b", if_ready, m_ready());
      end
      tick();
      checks++;
      if ({id_valid, id_pc, id_inst, count} !== {m_v, m_pc, m_inst, CW'(q.size())}) begin
        errors++;
        $display("FAIL rand_model got v=%b pc=%h inst=%h cnt=%0d want v=%b pc=%h inst=%h cnt=%0d",
                 id_valid, id_pc, id_inst, count, m_v, m_pc, m_inst, q.size());
      end
    end
    stall = '0; flush = 1'b0; if_valid = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) tick();
  endtask

  task automatic test_reset_mid();
    stall = 6'b000100;
    for (int c = 0; c < 2; c++) begin
      if_valid = 1'b1; if_pc = 32'h500 + 32'(4 * c); if_inst = $urandom;
      tick();
    end
    if_valid = 1'b0;
    stall = '0;
    tick();
    checks++;
    if (count !== 3'd1 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got cnt=%0d v=%b want cnt=1 v=1", count, id_valid);
    end
    if_valid = 1'b1; if_pc = 32'h600;
    tick();
    checks++;
    if (count !== 3'd1 || id_pc !== 32'h504) begin
      errors++;
      $display("FAIL mid_fill got cnt=%0d pc=%h want cnt=1 pc=504", count, id_pc);
    end
    stall = 6'b000100;
    tick();
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL mid_count got cnt=%0d want 2", count);
    end
    rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({if_ready, id_valid, id_pc, id_inst, count} !== '0) begin
      errors++;
      $display("FAIL mid_async got rdy=%b v=%b pc=%h cnt=%0d want all 0", if_ready, id_valid, id_pc, count);
    end
    if_valid = 1'b0; stall = '0;
    tick();
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({id_valid, count} !== '0) begin
        errors++;
        $display("FAIL mid_stale got v=%b pc=%h cnt=%0d want v=0 cnt=0", id_valid, id_pc, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_bubble();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID stage with a DEPTH-entry instruction queue between fetch and decode. Fetch pushes {pc, inst} with a valid/ready handshake; decode pops from the queue under control of the pipeline stall vector. A single-cycle flush empties the queue and the decode register, for redirects on branch, jump or exception. It replaces the plain IF/ID register so that fetch keeps running while decode is stalled.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- STALL_W, 6, stall vector width
- ID_STAGE, 2, index of the decode stage in the stall vector

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  STALL_W  pipeline stall vector; only bit ID_STAGE is used
- flush  in  1  discard all queued and decode-stage instructions
- if_valid  in  1  fetch presents an instruction
- if_pc  in  ADDR_W  address of the fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_ready  out  1  queue accepts a push this cycle
- id_valid  out  1  id_pc/id_inst hold a real instruction, not a bubble
- id_pc  out  ADDR_W  decode-stage address
- id_inst  out  INST_W  decode-stage instruction
- count  out  $clog2(DEPTH)+1  current queue occupancy, 0..DEPTH

## Operation
- Push: occurs when if_valid && if_ready.
  - if_ready = rst high && !full && !flush.
  - There is no push-through when full, even if a pop happens in the same cycle.
- Pop/load:
  - When stall[ID_STAGE]==0 (NoStop), the decode register loads the queue head and sets id_valid=1.
  - If the queue is empty, the decode register loads a bubble instead: id_pc=0, id_inst=0, id_valid=0.
- Hold: when stall[ID_STAGE]==1, the decode register and the queue head are unchanged; pushes still proceed.
- Flush (highest priority after reset):
  - Next edge: count=0, read and write pointers reset, id_pc=0, id_inst=0, id_valid=0.
  - A push presented in the flush cycle is dropped (if_ready=0).
- Simultaneous push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Reset (async assert): every output goes to 0 immediately, including if_ready; queue contents are don't-care. After release: if_ready=1, id_valid=0, count=0.
- Reset asserted mid-operation discards all in-flight entries; nothing is replayed.

## Timing
- Push-to-id_valid latency: 2 cycles (push edge, then load edge); 1 cycle with bypass (see Configuration).
- Back-to-back issue: one instruction per cycle sustained when decode is not stalled.
- count is registered, so occupancy is visible the cycle after the push or pop.
- if_ready is combinational from count, flush and rst; it does not depend on if_valid, so no combinational loop.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined:
  - Bypass condition: queue empty, stall[ID_STAGE]==0, no flush, and a push occurring.
  - Under that condition the push writes the decode register directly (id_valid=1 next edge) and is not enqueued.
  - This matches the one-cycle latency of the classic IF/ID register.
- Undefined: every instruction passes through the queue, giving a 2-cycle minimum latency and a simpler timing path.

## Structure
- Shared defines package holds:
  - RstEnable (1'b0 for this block)
  - ZeroWord
  - Stop/NoStop
  - InstAddrBus/InstBus widths as defaults for ADDR_W/INST_W
- Sub-module inst_fifo(DEPTH, W=ADDR_W+INST_W):
  - Contents: storage array, pointers, count, full/empty.
  - Ports: push, pop, clear.
  - The top level holds the decode register, the bubble/flush logic and the bypass mux.

## Test plan
- Reset release, then push pc=0x100/inst=0x24010001 with no stall → id_valid=1 with those values at +2 cycles (+1 with bypass); count returns to 0.
- Hold stall[2]=1, push 5 instructions with DEPTH=4 → if_ready drops after the 4th push, count=4. Release stall → pc 0x100,0x104,0x108,0x10C issue on consecutive cycles, then the 5th follows once accepted.
- Queue empty with no stall → id_valid=0, id_pc=0, id_inst=0 every cycle (bubble).
- Queue holding 3 entries, flush for one cycle while if_valid=1 → next cycle count=0, id_valid=0, if_ready=0 during flush; the next push issues normally.
- Continuous push and pop for 2·DEPTH+3 instructions → pointers wrap; output order and values match input exactly, with no drops or duplicates.
- Assert rst mid-burst with count=2 → outputs are 0 asynchronously before the next edge; after release, count=0 and no stale instruction appears.
